// File: rtl/bitstream_word_assembler.sv
// Byte-to-word stage: hunts the byte stream for the sync word, then packs
// every four bytes big-endian into a 32-bit word until the desync word lands.
module bitstream_word_assembler #(
    parameter logic [31:0] SYNC_WORD   = 32'hFAB0_FAB1,
    parameter logic [31:0] DESYNC_WORD = 32'hFAB0_FAB0,
    parameter int unsigned COUNT_WIDTH = 16
) (
    input  logic                   clk_i,
    input  logic                   reset_i,
    input  logic                   en_i,
    input  logic                   in_valid_i,
    output logic                   in_ready_o,
    input  logic [7:0]             data_in_i,
    output logic                   out_valid_o,
    input  logic                   out_ready_i,
    output logic [31:0]            data_out_o,
    output logic                   synced_o,
    output logic [COUNT_WIDTH-1:0] word_count_o
);

    typedef enum logic {
        HUNT   = 1'b0,
        SYNCED = 1'b1
    } state_e;

    state_e                 state_q,      state_d;
    logic [31:0]            shift_q,      shift_d;
    logic [1:0]             cnt_q,        cnt_d;
    logic                   out_valid_q,  out_valid_d;
    logic [31:0]            data_out_q,   data_out_d;
    logic [COUNT_WIDTH-1:0] word_count_q, word_count_d;

    logic        accept;
    logic [31:0] next_word;

    // A pending word blocks intake unless it is being taken this cycle.
    assign in_ready_o = en_i && (!out_valid_q || out_ready_i);
    assign accept     = in_valid_i && in_ready_o;
    assign next_word  = {shift_q[23:0], data_in_i};

    always_comb begin
        state_d      = state_q;
        shift_d      = shift_q;
        cnt_d        = cnt_q;
        out_valid_d  = out_valid_q;
        data_out_d   = data_out_q;
        word_count_d = word_count_q;

        if (out_valid_q && out_ready_i) begin
            out_valid_d = 1'b0;
        end

        if (accept) begin
            shift_d = next_word;
            unique case (state_q)
                HUNT: begin
                    if (next_word == SYNC_WORD) begin
                        state_d      = SYNCED;
                        cnt_d        = 2'd0;
                        word_count_d = '0;
                        shift_d      = '0;
                    end
                end
                SYNCED: begin
                    cnt_d = cnt_q + 2'd1;
                    if (cnt_q == 2'd3) begin
                        if (next_word == DESYNC_WORD) begin
                            state_d = HUNT;
                            shift_d = '0;
                        end else begin
                            data_out_d  = next_word;
                            out_valid_d = 1'b1;
                            if (word_count_q != {COUNT_WIDTH{1'b1}}) begin
                                word_count_d = word_count_q + COUNT_WIDTH'(1);
                            end
                        end
                    end
                end
                default: state_d = HUNT;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q      <= HUNT;
            shift_q      <= '0;
            cnt_q        <= '0;
            out_valid_q  <= 1'b0;
            data_out_q   <= '0;
            word_count_q <= '0;
        end else begin
            state_q      <= state_d;
            shift_q      <= shift_d;
            cnt_q        <= cnt_d;
            out_valid_q  <= out_valid_d;
            data_out_q   <= data_out_d;
            word_count_q <= word_count_d;
        end
    end

    assign out_valid_o  = out_valid_q;
    assign data_out_o   = data_out_q;
    assign synced_o     = (state_q == SYNCED);
    assign word_count_o = word_count_q;

endmodule

// File: tb/tb_bitstream_word_assembler.sv
// Bench for bitstream_word_assembler: scenario tasks push expected words into a
// scoreboard queue; a monitor pops and compares on every output handshake.
module tb_bitstream_word_assembler;

    logic        clk_i = 1'b0;
    logic        reset_i = 1'b0;
    logic        en_i = 1'b1;
    logic        in_valid_i = 1'b0;
    logic        in_ready_o;
    logic [7:0]  data_in_i = 8'h00;
    logic        out_valid_o;
    logic        out_ready_i = 1'b1;
    logic [31:0] data_out_o;
    logic        synced_o;
    logic [15:0] word_count_o;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    logic [31:0] exp_q[$];

    bitstream_word_assembler dut (
        .clk_i        (clk_i),
        .reset_i      (reset_i),
        .en_i         (en_i),
        .in_valid_i   (in_valid_i),
        .in_ready_o   (in_ready_o),
        .data_in_i    (data_in_i),
        .out_valid_o  (out_valid_o),
        .out_ready_i  (out_ready_i),
        .data_out_o   (data_out_o),
        .synced_o     (synced_o),
        .word_count_o (word_count_o)
    );

    always #5 clk_i = ~clk_i;
    always @(posedge clk_i) cyc <= cyc + 1;

    // Scoreboard: a handshake completes on the next rising edge.
    always @(negedge clk_i) begin
        if (!reset_i && out_valid_o && out_ready_i) begin
            logic [31:0] e;
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected_word: got %h, none expected", data_out_o);
            end else begin
                e = exp_q.pop_front();
                if (data_out_o !== e) begin
                    n_bad++;
                    $display("FAIL word_data: got %h, expected %h", data_out_o, e);
                end
            end
        end
    end

    task automatic send_byte(input logic [7:0] b);
        int t = 0;
        in_valid_i = 1'b1;
        data_in_i  = b;
        @(negedge clk_i);
        while (!in_ready_o && t < 200) begin
            @(negedge clk_i);
            t++;
        end
        if (!in_ready_o) begin
            n_cmp++;
            n_bad++;
            $display("FAIL byte_timeout: byte %h not accepted within 200 cycles", b);
        end
        @(posedge clk_i);
        #1;
        in_valid_i = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 3; i >= 0; i--) send_byte(w[i*8 +: 8]);
    endtask

    task automatic do_reset();
        @(posedge clk_i);
        #1;
        reset_i     = 1'b1;
        in_valid_i  = 1'b0;
        en_i        = 1'b1;
        out_ready_i = 1'b1;
        @(posedge clk_i);
        #1;
        reset_i = 1'b0;
    endtask

    task automatic drain_check(input string name);
        repeat (3) @(posedge clk_i);
        #1;
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL %s_drain: %0d words still expected, expected 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++;
        if (out_valid_o !== 1'b0 || data_out_o !== 32'h0 || synced_o !== 1'b0 ||
            word_count_o !== 16'h0 || in_ready_o !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_state: v=%b d=%h s=%b c=%0d r=%b, expected 0 0 0 0 1",
                     out_valid_o, data_out_o, synced_o, word_count_o, in_ready_o);
        end
    endtask

    task automatic test_basic();
        int vcyc = 0;
        do_reset();
        send_word(32'hFAB0_FAB1);
        n_cmp++;
        if (synced_o !== 1'b1 || word_count_o !== 16'd0) begin
            n_bad++;
            $display("FAIL basic_sync: synced=%b count=%0d, expected 1 0", synced_o, word_count_o);
        end
        exp_q.push_back(32'h0102_0304);
        send_word(32'h0102_0304);
        n_cmp++;
        if (out_valid_o !== 1'b1 || word_count_o !== 16'd1) begin
            n_bad++;
            $display("FAIL basic_latency: valid=%b count=%0d, expected 1 1", out_valid_o, word_count_o);
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk_i);
            if (out_valid_o) vcyc++;
        end
        n_cmp++;
        if (vcyc != 1) begin
            n_bad++;
            $display("FAIL basic_valid_width: valid high %0d cycles, expected 1", vcyc);
        end
        drain_check("basic");
    endtask

    task automatic test_unaligned();
        logic [7:0] pre [6] = '{8'h00, 8'hFA, 8'hFA, 8'hB0, 8'hFA, 8'hB1};
        do_reset();
        for (int i = 0; i < 6; i++) begin
            send_byte(pre[i]);
            if (i == 4) begin
                n_cmp++;
                if (synced_o !== 1'b0) begin
                    n_bad++;
                    $display("FAIL unaligned_early_sync: synced=%b, expected 0", synced_o);
                end
            end
        end
        exp_q.push_back(32'hDEAD_BEEF);
        send_word(32'hDEAD_BEEF);
        n_cmp++;
        if (synced_o !== 1'b1 || word_count_o !== 16'd1) begin
            n_bad++;
            $display("FAIL unaligned_state: synced=%b count=%0d, expected 1 1", synced_o, word_count_o);
        end
        drain_check("unaligned");
    endtask

    task automatic test_backpressure();
        do_reset();
        send_word(32'hFAB0_FAB1);
        out_ready_i = 1'b0;
        exp_q.push_back(32'h1112_1314);
        exp_q.push_back(32'h1516_1718);
        send_word(32'h1112_1314);
        fork
            send_word(32'h1516_1718);
            begin
                int bad = 0;
                for (int i = 0; i < 6; i++) begin
                    @(negedge clk_i);
                    if (in_ready_o !== 1'b0 || out_valid_o !== 1'b1 || data_out_o !== 32'h1112_1314) bad++;
                end
                n_cmp++;
                if (bad != 0) begin
                    n_bad++;
                    $display("FAIL backpressure_stall: %0d bad stall cycles (ready=%b valid=%b data=%h), expected 0",
                             bad, in_ready_o, out_valid_o, data_out_o);
                end
                @(posedge clk_i);
                #1;
                out_ready_i = 1'b1;
            end
        join
        drain_check("backpressure");
        n_cmp++;
        if (word_count_o !== 16'd2) begin
            n_bad++;
            $display("FAIL backpressure_count: count=%0d, expected 2", word_count_o);
        end
    endtask

    task automatic test_desync();
        do_reset();
        send_word(32'hFAB0_FAB1);
        exp_q.push_back(32'hAABB_CCDD);
        send_word(32'hAABB_CCDD);
        exp_q.push_back(32'hFAB0_FAB1);
        send_word(32'hFAB0_FAB1);
        n_cmp++;
        if (synced_o !== 1'b1 || word_count_o !== 16'd2) begin
            n_bad++;
            $display("FAIL sync_as_data: synced=%b count=%0d, expected 1 2", synced_o, word_count_o);
        end
        send_word(32'hFAB0_FAB0);
        n_cmp++;
        if (synced_o !== 1'b0 || word_count_o !== 16'd2) begin
            n_bad++;
            $display("FAIL desync_state: synced=%b count=%0d, expected 0 2", synced_o, word_count_o);
        end
        send_word(32'h0102_0304);
        drain_check("desync");
        send_word(32'hFAB0_FAB1);
        n_cmp++;
        if (synced_o !== 1'b1 || word_count_o !== 16'd0) begin
            n_bad++;
            $display("FAIL resync_state: synced=%b count=%0d, expected 1 0", synced_o, word_count_o);
        end
    endtask

    task automatic test_mid_reset();
        do_reset();
        send_word(32'hFAB0_FAB1);
        exp_q.push_back(32'h5566_7788);
        send_word(32'h5566_7788);
        send_byte(8'h01);
        send_byte(8'h02);
        #2;
        reset_i = 1'b1;
        #1;
        n_cmp++;
        if (out_valid_o !== 1'b0 || data_out_o !== 32'h0 || synced_o !== 1'b0 || word_count_o !== 16'h0) begin
            n_bad++;
            $display("FAIL async_reset: v=%b d=%h s=%b c=%0d, expected all 0",
                     out_valid_o, data_out_o, synced_o, word_count_o);
        end
        @(posedge clk_i);
        #1;
        reset_i = 1'b0;
        send_word(32'h0304_0506);
        drain_check("mid_reset");
        n_cmp++;
        if (synced_o !== 1'b0) begin
            n_bad++;
            $display("FAIL mid_reset_hunt: synced=%b, expected 0", synced_o);
        end
    endtask

    task automatic test_enable();
        int bad = 0;
        do_reset();
        send_word(32'hFAB0_FAB1);
        exp_q.push_back(32'h2122_2324);
        send_byte(8'h21);
        send_byte(8'h22);
        en_i = 1'b0;
        in_valid_i = 1'b1;
        data_in_i = 8'h23;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk_i);
            if (in_ready_o !== 1'b0 || synced_o !== 1'b1 || out_valid_o !== 1'b0) bad++;
        end
        n_cmp++;
        if (bad != 0) begin
            n_bad++;
            $display("FAIL enable_stall: %0d bad cycles, expected 0", bad);
        end
        @(posedge clk_i);
        #1;
        en_i = 1'b1;
        send_byte(8'h23);
        send_byte(8'h24);
        drain_check("enable");
    endtask

    task automatic test_back_to_back();
        int c0;
        do_reset();
        send_word(32'hFAB0_FAB1);
        for (int w = 0; w < 4; w++) exp_q.push_back(32'hC0C1_C2C3 + 32'(w) * 32'h0404_0404);
        c0 = cyc;
        for (int w = 0; w < 4; w++) send_word(32'hC0C1_C2C3 + 32'(w) * 32'h0404_0404);
        n_cmp++;
        if (cyc - c0 != 16) begin
            n_bad++;
            $display("FAIL back_to_back_rate: %0d cycles for 16 bytes, expected 16", cyc - c0);
        end
        drain_check("back_to_back");
        n_cmp++;
        if (word_count_o !== 16'd4) begin
            n_bad++;
            $display("FAIL back_to_back_count: count=%0d, expected 4", word_count_o);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_unaligned();
        test_backpressure();
        test_desync();
        test_mid_reset();
        test_enable();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
